// File: rtl/golden_fetch_queue.sv
// Instruction prefetch queue: issues sequential reads ahead of the core, buffers DEPTH {instr, pc} entries, flushes on redirect.
// A response in cycle N is visible on fetch_* in N+1; a full queue stalls issue only, and responses are always accepted.
module golden_fetch_queue #(
  parameter int INSTR_WIDTH = 16,
  parameter int ADDR_WIDTH  = 10,
  parameter int DEPTH       = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   mem_req,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic                   mem_ready,
  input  logic                   mem_rvalid,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  output logic                   fetch_valid,
  output logic [INSTR_WIDTH-1:0] fetch_instr,
  output logic [ADDR_WIDTH-1:0]  fetch_pc,
  input  logic                   fetch_ready,
  input  logic                   redirect,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  input  logic                   halt
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic                   run;
  logic [ADDR_WIDTH-1:0]  issue_pc;
  logic [ADDR_WIDTH-1:0]  resp_pc;
  logic [CW-1:0]          count;
  logic [CW-1:0]          outstanding;
  logic [CW-1:0]          discard;
  logic [CW-1:0]          out_nxt;
  logic [PW-1:0]          rd_ptr;
  logic [PW-1:0]          wr_ptr;
  logic [INSTR_WIDTH-1:0] instr_q [DEPTH];
  logic [ADDR_WIDTH-1:0]  pc_q    [DEPTH];

  logic credit;
  logic accept;
  logic resp;
  logic push;
  logic pop;

  // Buffered plus in-flight entries never exceed DEPTH, so a response always has a free slot.
  assign credit      = ({1'b0, count} + {1'b0, outstanding}) < DEPTH_C;
  assign mem_req     = run & ~halt & ~redirect & credit;
  assign mem_addr    = issue_pc;
  assign accept      = mem_req & mem_ready;
  assign resp        = mem_rvalid & (outstanding != '0);
  assign push        = resp & (discard == '0) & ~redirect;
  assign fetch_valid = (count != '0);
  assign pop         = fetch_valid & fetch_ready & ~redirect;
  assign fetch_instr = instr_q[rd_ptr];
  assign fetch_pc    = pc_q[rd_ptr];

  always_comb begin
    out_nxt = outstanding;
    if (accept) out_nxt = out_nxt + CW'(1);
    if (resp)   out_nxt = out_nxt - CW'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run         <= 1'b0;
      issue_pc    <= '0;
      resp_pc     <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      run         <= 1'b1;
      outstanding <= out_nxt;
      if (redirect) begin
        // Everything still in flight, including this cycle's accept/response accounting, is stale.
        issue_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        count    <= '0;
        discard  <= out_nxt;
        wr_ptr   <= rd_ptr;
      end else begin
        if (accept) issue_pc <= issue_pc + ADDR_WIDTH'(1);
        if (resp && (discard != '0)) discard <= discard - CW'(1);
        if (push) begin
          instr_q[wr_ptr] <= mem_rdata;
          pc_q[wr_ptr]    <= resp_pc;
          wr_ptr          <= wr_ptr + PW'(1);
          resp_pc         <= resp_pc + ADDR_WIDTH'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // A response with nothing in flight breaks the memory protocol.
  assert property (@(posedge clock) disable iff (!reset) mem_rvalid |-> (outstanding != '0));

endmodule

// File: tb/tb_golden_fetch_queue.sv
// Directed bench for golden_fetch_queue: vector tables per cycle plus a hand-written async reset sequence.
module tb_golden_fetch_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req;
  logic [9:0]  mem_addr;
  logic        mem_ready = 1'b1;
  logic        mem_rvalid = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        fetch_valid;
  logic [15:0] fetch_instr;
  logic [9:0]  fetch_pc;
  logic        fetch_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [9:0]  redirect_pc = '0;
  logic        halt = 1'b0;

  golden_fetch_queue dut (
    .clock       (clock),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_pc    (fetch_pc),
    .fetch_ready (fetch_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         rst;
    bit         fr;
    bit         hl;
    bit         rd;
    logic [9:0] rpc;
    bit         req;
    logic [9:0] addr;
    bit         fv;
    logic [9:0] pc;
  } vec_t;

  typedef struct {
    int         due;
    logic [9:0] addr;
  } pend_t;

  vec_t  tbl[$];
  pend_t pend[$];
  int    lat = 1;
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic row(input bit rst, input bit fr, input bit hl, input bit rd, input logic [9:0] rpc,
                     input bit req, input logic [9:0] addr, input bit fv, input logic [9:0] pc);
    vec_t v;
    v.rst = rst; v.fr = fr; v.hl = hl; v.rd = rd; v.rpc = rpc;
    v.req = req; v.addr = addr; v.fv = fv; v.pc = pc;
    tbl.push_back(v);
  endtask

  task automatic rst_row();
    row(1, 0, 0, 0, 10'h0, 0, 10'h0, 0, 10'h0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic mem_flush();
    pend.delete();
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  // Memory model: fixed latency, in order, returns the zero-extended word address as data.
  task automatic adv();
    bit         acc;
    logic [9:0] a;
    acc = (mem_req === 1'b1) && mem_ready;
    a   = mem_addr;
    @(posedge clock);
    #1;
    if (!reset) begin
      mem_flush();
    end else if (acc) begin
      pend_t p;
      p.due  = cyc + lat;
      p.addr = a;
      pend.push_back(p);
    end
    cyc++;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 16'(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      mem_rvalid = 1'b0;
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    reset = v.rst ? 1'b0 : 1'b1;
    if (v.rst) mem_flush();
    fetch_ready = v.fr;
    halt        = v.hl;
    redirect    = v.rd;
    redirect_pc = v.rpc;
    @(negedge clock);
    check($sformatf("%s mem_req", tag), 32'(mem_req), 32'(v.req));
    check($sformatf("%s mem_addr", tag), 32'(mem_addr), 32'(v.addr));
    check($sformatf("%s fetch_valid", tag), 32'(fetch_valid), 32'(v.fv));
    if (v.fv || v.rst) begin
      check($sformatf("%s fetch_pc", tag), 32'(fetch_pc), 32'(v.pc));
      check($sformatf("%s fetch_instr", tag), 32'(fetch_instr), 32'(v.pc));
    end
    adv();
  endtask

  task automatic run_table(input string nm);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("%s[%0d]", nm, i));
    tbl.delete();
  endtask

  task automatic backpressure_head();
    row(0, 0, 0, 0, 10'h0, 0, 10'h0, 0, 10'h0);
    row(0, 0, 0, 0, 10'h0, 1, 10'h0, 0, 10'h0);
    row(0, 0, 0, 0, 10'h0, 1, 10'h1, 0, 10'h0);
    row(0, 0, 0, 0, 10'h0, 1, 10'h2, 1, 10'h0);
    row(0, 0, 0, 0, 10'h0, 1, 10'h3, 1, 10'h0);
  endtask

  initial begin
    // Streaming and backpressure, 1-cycle memory.
    lat = 1;
    rst_row();
    row(0, 1, 0, 0, 10'h0, 0, 10'h0, 0, 10'h0);
    row(0, 1, 0, 0, 10'h0, 1, 10'h0, 0, 10'h0);
    row(0, 1, 0, 0, 10'h0, 1, 10'h1, 0, 10'h0);
    for (int k = 3; k < 8; k++) row(0, 1, 0, 0, 10'h0, 1, 10'(k - 1), 1, 10'(k - 3));
    rst_row();
    backpressure_head();
    row(0, 0, 0, 0, 10'h0, 0, 10'h4, 1, 10'h0);
    row(0, 0, 0, 0, 10'h0, 0, 10'h4, 1, 10'h0);
    row(0, 0, 0, 0, 10'h0, 0, 10'h4, 1, 10'h0);
    row(0, 1, 0, 0, 10'h0, 0, 10'h4, 1, 10'h0);
    row(0, 1, 0, 0, 10'h0, 1, 10'h4, 1, 10'h1);
    row(0, 1, 0, 0, 10'h0, 1, 10'h5, 1, 10'h2);
    row(0, 1, 0, 0, 10'h0, 1, 10'h6, 1, 10'h3);
    row(0, 1, 0, 0, 10'h0, 1, 10'h7, 1, 10'h4);
    run_table("lat1");

    // Redirect, redirect-with-response, wrap and halt, 3-cycle memory.
    lat = 3;
    rst_row();
    row(0, 0, 0, 0, 10'h0,   0, 10'h0,   0, 10'h0);
    row(0, 0, 0, 0, 10'h0,   1, 10'h0,   0, 10'h0);
    row(0, 0, 1, 0, 10'h0,   0, 10'h1,   0, 10'h0);
    row(0, 0, 1, 0, 10'h0,   0, 10'h1,   0, 10'h0);
    row(0, 0, 0, 0, 10'h0,   1, 10'h1,   0, 10'h0);
    row(0, 0, 0, 0, 10'h0,   1, 10'h2,   1, 10'h0);
    row(0, 0, 0, 1, 10'h030, 0, 10'h3,   1, 10'h0);
    row(0, 1, 0, 0, 10'h0,   1, 10'h030, 0, 10'h0);
    row(0, 1, 0, 0, 10'h0,   1, 10'h031, 0, 10'h0);
    row(0, 1, 0, 0, 10'h0,   1, 10'h032, 0, 10'h0);
    row(0, 1, 0, 0, 10'h0,   1, 10'h033, 0, 10'h0);
    row(0, 1, 0, 0, 10'h0,   0, 10'h034, 1, 10'h030);
    row(0, 1, 0, 0, 10'h0,   1, 10'h034, 1, 10'h031);
    row(0, 1, 0, 0, 10'h0,   1, 10'h035, 1, 10'h032);
    rst_row();
    row(0, 1, 0, 0, 10'h0,   0, 10'h0,   0, 10'h0);
    for (int k = 1; k < 5; k++) row(0, 1, 0, 0, 10'h0, 1, 10'(k - 1), 0, 10'h0);
    row(0, 1, 0, 1, 10'h100, 0, 10'h4,   1, 10'h0);
    for (int k = 0; k < 4; k++) row(0, 1, 0, 0, 10'h0, 1, 10'(10'h100 + k), 0, 10'h0);
    row(0, 1, 0, 0, 10'h0,   0, 10'h104, 1, 10'h100);
    rst_row();
    row(0, 1, 0, 1, 10'h3FE, 0, 10'h0,   0, 10'h0);
    row(0, 1, 0, 0, 10'h0,   1, 10'h3FE, 0, 10'h0);
    row(0, 1, 0, 0, 10'h0,   1, 10'h3FF, 0, 10'h0);
    row(0, 1, 1, 0, 10'h0,   0, 10'h000, 0, 10'h0);
    row(0, 1, 1, 0, 10'h0,   0, 10'h000, 0, 10'h0);
    row(0, 1, 1, 0, 10'h0,   0, 10'h000, 1, 10'h3FE);
    row(0, 1, 1, 0, 10'h0,   0, 10'h000, 1, 10'h3FF);
    row(0, 1, 1, 0, 10'h0,   0, 10'h000, 0, 10'h0);
    for (int k = 0; k < 4; k++) row(0, 1, 0, 0, 10'h0, 1, 10'(k), 0, 10'h0);
    row(0, 1, 0, 0, 10'h0,   0, 10'h004, 1, 10'h000);
    run_table("lat3");

    // Reset asserted between clock edges with count=3, outstanding=1.
    lat = 1;
    rst_row();
    backpressure_head();
    run_table("midrst");
    @(negedge clock);
    check("midrst pre mem_req", 32'(mem_req), 32'h0);
    check("midrst pre fetch_valid", 32'(fetch_valid), 32'h1);
    #2;
    reset = 1'b0;
    mem_flush();
    #1;
    check("midrst async mem_req", 32'(mem_req), 32'h0);
    check("midrst async mem_addr", 32'(mem_addr), 32'h0);
    check("midrst async fetch_valid", 32'(fetch_valid), 32'h0);
    check("midrst async fetch_pc", 32'(fetch_pc), 32'h0);
    check("midrst async fetch_instr", 32'(fetch_instr), 32'h0);
    adv();
    reset = 1'b1;
    @(negedge clock);
    check("midrst release mem_req", 32'(mem_req), 32'h0);
    adv();
    @(negedge clock);
    check("midrst first mem_req", 32'(mem_req), 32'h1);
    check("midrst first mem_addr", 32'(mem_addr), 32'h0);
    adv();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
